i2s_dac_tx: RTL
===============

Name: i2s_dac_tx

Overview:
- Stereo I2S transmitter driving an external audio DAC (PCM5102-class); the output-side counterpart of the board's PCM1801 ADC capture path.
- Generates BCK, LRCK and serial data as master from the system clock.
- Accepts 16-bit left/right sample pairs through a valid/ready handshake into a one-deep holding buffer.
- Shifts each pair out MSB-first, one pair per frame.

Parameters:
- DATA_W, 16: sample width per channel.
- BCK_DIV, 2: clk cycles per BCK half-period (BCK period = 2*BCK_DIV clks); must be >= 1.
- SLOT_BITS, 32: BCK periods per channel slot; must be >= DATA_W+1. Frame = 2*SLOT_BITS BCK = 4*BCK_DIV*SLOT_BITS clks (256 at defaults).

Ports:
- clk  in  1  system/master clock, 256*fs at defaults.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  holding buffer empty; pair accepted on in_valid&&in_ready.
- in_left  in  DATA_W  left sample, two's complement.
- in_right  in  DATA_W  right sample, two's complement.
- bck  out  1  bit clock; DAC samples on rising edge.
- lrck  out  1  0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first.
- frame_start  out  1  one-clk pulse on the frame-load cycle.
- underrun  out  1  one-clk pulse when a frame loads with the holding buffer empty.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - bck=0, lrck=0, sdata=0, frame_start=0, underrun=0, in_ready=0.
  - div_cnt=0, bit_cnt=0, holding empty, shift regs zero.
  - in_ready=1 from the first cycle after reset release.
  - Reset mid-frame aborts the frame immediately; the holding buffer is discarded.
- Timing:
  - div_cnt counts 0..BCK_DIV-1; on wrap bck toggles.
  - On each bck 1->0 toggle, bit_cnt advances mod 2*SLOT_BITS, and lrck and sdata update in the same clk edge. All outputs are registered, so bck and sdata edges coincide.
  - lrck = (bit_cnt >= SLOT_BITS).
- Frame load: occurs on the falling toggle where bit_cnt wraps to 0.
  - Holding full: left/right are copied into the shift regs, holding becomes empty, frame_start=1.
  - Holding empty: shift regs are loaded with zeros, frame_start=1, underrun=1.
  - The post-reset state counts as slot 0 of a zero frame; there is no frame_start pulse for it.
- Bit mapping (I2S, one-BCK delay), with s = bit_cnt mod SLOT_BITS:
  - sdata = sample[DATA_W-s] for s in 1..DATA_W.
  - Otherwise sdata = 0, including s=0.
  - The left sample is used while lrck=0, the right while lrck=1.
- Handshake:
  - Acceptance only when the holding buffer is empty; in_ready is the registered inverse of holding-full.
  - On the frame-load cycle in_ready is still 0; it rises on the next clk.
  - in_left/in_right are ignored when not accepted.
  - Latency: an accepted pair's left MSB appears on sdata 1 BCK after the next frame load.
- Width/arith: no arithmetic on samples; counter widths use $clog2 of BCK_DIV and 2*SLOT_BITS.

Optional Feature:
- Macro I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format matching the PCM1801 side. sdata = sample[DATA_W-1-s] for s in 0..DATA_W-1, else 0. LRCK polarity is inverted (1 = left, 0 = right); frame load and handshake are unchanged.
- Undefined: standard I2S mapping as above.

Decomposition:
- Package i2s_pkg: format constants (FMT_I2S, FMT_LJ), default DATA_W/BCK_DIV/SLOT_BITS, helper function for counter widths.
- One sub-module, i2s_tx_timing: div_cnt/bit_cnt, bck/lrck generation, and fall-edge and frame-load strobes.
- Top level holds the holding buffer, shift regs and handshake.

Test Plan:
- Defaults; after reset push L=16'hA5C3, R=16'h0F01:
  - frame_start after 256 clks.
  - sdata in left slot bits 1..16 reads 1010_0101_1100_0011, bits 17..31 and bit 0 read 0.
  - Right slot bits 1..16 read 0000_1111_0000_0001.
  - bck period = 4 clks, lrck period = 256 clks.
- No in_valid for 3 frames -> underrun pulses 3 times and sdata stays 0 throughout.
- Hold in_valid=1 continuously with an incrementing pattern:
  - Exactly one acceptance per frame, in_ready low between acceptance and the next load.
  - No sample dropped or duplicated across 8 frames.
- Assert rst_n=0 at bit_cnt=20 of a left slot with a pair pending -> next clk all outputs 0, in_ready=0; after release, the first frame transmits zeros with an underrun pulse.
- BCK_DIV=1, SLOT_BITS=17:
  - Frame = 68 clks.
  - Left MSB appears at bit 1, LSB at bit 16, no zero padding after the LSB.
- I2S_TX_LEFT_JUSTIFIED_EN defined, L=16'h8001 -> MSB '1' at bit 0 of the slot while lrck=1, LSB '1' at bit 15.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - I2S transmitter format constants, defaults and width helper.
// Defining I2S_TX_LEFT_JUSTIFIED_EN selects the left-justified output format.
package i2s_pkg;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BCK_DIV   = 2;
    localparam int DEF_SLOT_BITS = 32;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam fmt_e TX_FMT = FMT_LJ;
`else
    localparam fmt_e TX_FMT = FMT_I2S;
`endif

    // Width of a counter holding values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_tx_timing.sv
// rtl/i2s_tx_timing.sv - BCK divider, bit counter, LRCK and fall/frame-load strobes.
// LRCK polarity follows I2S_TX_LEFT_JUSTIFIED_EN through i2s_pkg::TX_FMT.
module i2s_tx_timing
    import i2s_pkg::*;
#(
    parameter  int BCK_DIV   = DEF_BCK_DIV,
    parameter  int SLOT_BITS = DEF_SLOT_BITS,
    localparam int BW        = cnt_w(2 * SLOT_BITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          bck,
    output logic          lrck,
    output logic          fall,
    output logic          frame_load,
    output logic [BW-1:0] bit_nxt
);

    localparam int            DW       = cnt_w(BCK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          wrap;

    // bit_nxt is the bit position that becomes current on a falling toggle.
    always_comb begin
        wrap       = (div_cnt == DIV_LAST);
        fall       = wrap && bck;
        frame_load = fall && (bit_cnt == BIT_LAST);
        bit_nxt    = frame_load ? '0 : bit_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bck     <= 1'b0;
            lrck    <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) begin
                bck <= ~bck;
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= (bit_nxt >= SLOT) ^ (TX_FMT == FMT_LJ);
            end
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - Stereo I2S master transmitter with one-deep sample holding buffer.
// Format: standard I2S, or left-justified when I2S_TX_LEFT_JUSTIFIED_EN is defined.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BCK_DIV   = DEF_BCK_DIV,
    parameter int SLOT_BITS = DEF_SLOT_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    output logic              bck,
    output logic              lrck,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun
);

    localparam int            BW   = cnt_w(2 * SLOT_BITS);
    localparam int            IW   = cnt_w(DATA_W);
    localparam logic [BW-1:0] SLOT = BW'(SLOT_BITS);

    logic              fall;
    logic              frame_load;
    logic [BW-1:0]     bit_nxt;

    logic              hold_full;
    logic              hold_full_nxt;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] sh_l;
    logic [DATA_W-1:0] sh_r;

    logic              accept;
    logic [DATA_W-1:0] cur_l;
    logic [DATA_W-1:0] cur_r;
    logic [DATA_W-1:0] smp;
    logic [BW-1:0]     s;
    logic [IW-1:0]     idx;
    logic              bit_val;
    int                s_i;

    i2s_tx_timing #(
        .BCK_DIV   (BCK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .bck        (bck),
        .lrck       (lrck),
        .fall       (fall),
        .frame_load (frame_load),
        .bit_nxt    (bit_nxt)
    );

    // On the load edge the new frame's samples are not yet in sh_l/sh_r, so
    // the bit driven at that edge is taken from what is being loaded.
    always_comb begin
        accept  = in_valid && in_ready;
        cur_l   = frame_load ? (hold_full ? hold_l : '0) : sh_l;
        cur_r   = frame_load ? (hold_full ? hold_r : '0) : sh_r;
        smp     = (bit_nxt < SLOT) ? cur_l : cur_r;
        s       = (bit_nxt < SLOT) ? bit_nxt : bit_nxt - SLOT;
        s_i     = int'(s);
        idx     = '0;
        bit_val = 1'b0;
        if (TX_FMT == FMT_LJ) begin
            if (s_i < DATA_W) begin
                idx     = IW'(DATA_W - 1 - s_i);
                bit_val = smp[idx];
            end
        end else begin
            if (s_i >= 1 && s_i <= DATA_W) begin
                idx     = IW'(DATA_W - s_i);
                bit_val = smp[idx];
            end
        end
        hold_full_nxt = accept ? 1'b1 : (frame_load ? 1'b0 : hold_full);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            if (accept) begin
                hold_l <= in_left;
                hold_r <= in_right;
            end
            if (frame_load) begin
                sh_l <= cur_l;
                sh_r <= cur_r;
            end
            if (fall) begin
                sdata <= bit_val;
            end
            hold_full   <= hold_full_nxt;
            in_ready    <= !hold_full_nxt && !frame_load;
            frame_start <= frame_load;
            underrun    <= frame_load && !hold_full;
        end
    end

endmodule
